// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary widths and bubble control constants for the
// IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
package pipe_pkg;

    localparam int IFID_DATA_W  = 96;
    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_DATA_W  = 160;
    localparam int IDEX_CTRL_W  = 12;
    localparam int EXMEM_DATA_W = 101;
    localparam int EXMEM_CTRL_W = 5;
    localparam int MEMWB_DATA_W = 101;
    localparam int MEMWB_CTRL_W = 3;

    // ID/EX control layout; every side-effecting bit is zero in a bubble
    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       memRead;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] resultSrc;
        logic [2:0] aluCntrl;
        logic       aluSrc;
    } idexCtrl_t;

    localparam logic [IFID_CTRL_W-1:0]  IFID_BUBBLE_CTRL  = '0;
    localparam logic [IDEX_CTRL_W-1:0]  IDEX_BUBBLE_CTRL  = '0;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_BUBBLE_CTRL = '0;
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_BUBBLE_CTRL = '0;

    function automatic logic [IDEX_CTRL_W-1:0] idexPack(input idexCtrl_t c);
        return c;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry holding register with valid; catches the beat accepted while the
// downstream output register is stalled.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] dIn,
    output logic         valid,
    output logic [W-1:0] dOut
);

    always_ff @(posedge clk) begin
        if (rst || clear)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (unload)
            valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (load)
            dOut <= dIn;
    end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage register with flush and bubble-forced control.
// Define PIPE_STAGE_SKID_EN for a one-entry skid and registered in_ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int                 DATA_W      = IDEX_DATA_W,
    parameter int                 CTRL_W      = IDEX_CTRL_W,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              outValidQ;
    logic [DATA_W-1:0] outDataQ;
    logic [CTRL_W-1:0] outCtrlQ;

    logic              inXfer;
    logic              outXfer;
    logic              loadOut;
    logic              nextValid;
    logic [DATA_W-1:0] nextData;
    logic [CTRL_W-1:0] nextCtrl;

    assign inXfer  = in_valid && in_ready;
    assign outXfer = outValidQ && out_ready;
    assign loadOut = !outValidQ || out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic                     skidValid;
    logic [DATA_W+CTRL_W-1:0] skidQ;

    pipe_skid_buf #(.W(DATA_W + CTRL_W)) uSkid (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush),
        .load   (inXfer && !loadOut),
        .unload (outXfer && skidValid),
        .dIn    ({in_ctrl, in_data}),
        .valid  (skidValid),
        .dOut   (skidQ)
    );

    // Ready depends only on state, so no out_ready path reaches upstream
    assign in_ready  = !rst && !skidValid;
    assign nextValid = skidValid || inXfer;
    assign nextData  = skidValid ? skidQ[DATA_W-1:0] : in_data;
    assign nextCtrl  = skidValid ? skidQ[DATA_W +: CTRL_W] : in_ctrl;
`else
    assign in_ready  = !rst && loadOut;
    assign nextValid = inXfer;
    assign nextData  = in_data;
    assign nextCtrl  = in_ctrl;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            outValidQ <= 1'b0;
            outDataQ  <= '0;
            outCtrlQ  <= BUBBLE_CTRL;
        end else if (flush) begin
            outValidQ <= 1'b0;
            outCtrlQ  <= BUBBLE_CTRL;
        end else if (loadOut) begin
            outValidQ <= nextValid;
            if (nextValid) begin
                outDataQ <= nextData;
                outCtrlQ <= nextCtrl;
            end else begin
                // drained: data is left as-is, control becomes harmless
                outCtrlQ <= BUBBLE_CTRL;
            end
        end
    end

    assign out_valid = outValidQ;
    assign out_data  = outDataQ;
    assign out_ctrl  = outCtrlQ;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed table plus hand sequences and a random queue-model run for pipe_stage.
// Expectations follow the build selected by PIPE_STAGE_SKID_EN.
module tb_pipe_stage;

    localparam int             DW  = 32;
    localparam int             CW  = 12;
    localparam logic [CW-1:0]  BUB = 12'hB0B;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;

    pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [DW-1:0] d,
                         input logic [CW-1:0] c, input logic o, input logic f);
        rst = r; in_valid = v; in_data = d; in_ctrl = c; out_ready = o; flush = f;
    endtask

    typedef struct {
        logic          rstV;
        logic          inV;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          oRdy;
        logic          chkData;
        logic          expRdy;
        logic          expV;
        logic [DW-1:0] expD;
        logic [CW-1:0] expC;
    } vec_t;

    vec_t                tbl[13];
    logic [DW-1:0]       pend[3];
    logic                stallRdy[4];
    logic [DW-1:0]       got[$];
    logic [CW+DW-1:0]    q[$];
    logic [CW+DW-1:0]    head;
    int                  idx;
    logic                acc, expRdy, pop;

    initial begin
        for (int i = 0; i < 3; i++)
            tbl[i] = '{rstV:1'b1, inV:1'b1, d:32'h99, c:12'h0A5, oRdy:1'b1, chkData:1'b1,
                       expRdy:1'b0, expV:1'b0, expD:32'h0, expC:BUB};
        tbl[3] = '{rstV:1'b0, inV:1'b0, d:32'h0, c:12'h0, oRdy:1'b1, chkData:1'b1,
                   expRdy:1'b1, expV:1'b0, expD:32'h0, expC:BUB};
        for (int k = 1; k <= 8; k++)
            tbl[3+k] = '{rstV:1'b0, inV:1'b1, d:DW'(k), c:12'h0A5, oRdy:1'b1, chkData:1'b1,
                         expRdy:1'b1, expV:1'b1, expD:DW'(k), expC:12'h0A5};
        tbl[12] = '{rstV:1'b0, inV:1'b0, d:32'h0, c:12'h0, oRdy:1'b1, chkData:1'b0,
                    expRdy:1'b1, expV:1'b0, expD:32'h0, expC:BUB};

        // reset with in_valid high, then streaming 1..8 and a drain
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rstV, tbl[i].inV, tbl[i].d, tbl[i].c, tbl[i].oRdy, 1'b0);
            #1;
            check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].expRdy);
            tick();
            check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].expV);
            check($sformatf("vec%0d_out_ctrl", i), out_ctrl, tbl[i].expC);
            if (tbl[i].chkData)
                check($sformatf("vec%0d_out_data", i), out_data, tbl[i].expD);
        end

        // stall four cycles with three pending beats, then release
        pend[0] = 32'h11; pend[1] = 32'h22; pend[2] = 32'h33;
        stallRdy[0] = 1'b1; stallRdy[1] = SKID; stallRdy[2] = 1'b0; stallRdy[3] = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, idx < 3, pend[idx < 3 ? idx : 2], 12'h0A5, 1'b0, 1'b0);
            #1;
            check("stall_in_ready", in_ready, stallRdy[c]);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_data", out_data, 32'h11);
        end
        check("stall_accepted", idx, SKID ? 2 : 1);
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, idx < 3, pend[idx < 3 ? idx : 2], 12'h0A5, 1'b1, 1'b0);
            #1;
            if (out_valid) got.push_back(out_data);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        check("release_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            check("release_order", i < got.size() ? 64'(got[i]) : 64'hDEAD, pend[i]);

        // flush while stalled, with a competing input beat 0x44
        drive(1'b0, 1'b1, 32'h55, 12'h0A5, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h66, 12'h0A5, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h44, 12'h0A5, 1'b0, 1'b1);
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        tick();
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_out_ctrl", out_ctrl, BUB);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 32'h0, 12'h0, 1'b1, 1'b0);
            #1;
            check("postflush_in_ready", in_ready, 1'b1);
            check("postflush_out_valid", out_valid, 1'b0);
            check("postflush_out_ctrl", out_ctrl, BUB);
            tick();
        end

        // flush beats an input beat that does handshake
        drive(1'b0, 1'b1, 32'h45, 12'h0A5, 1'b1, 1'b1);
        #1;
        check("flushxfer_in_ready", in_ready, 1'b1);
        tick();
        check("flushxfer_out_valid", out_valid, 1'b0);
        check("flushxfer_out_ctrl", out_ctrl, BUB);
        drive(1'b0, 1'b0, 32'h0, 12'h0, 1'b1, 1'b0);
        tick();
        check("flushxfer_stays_empty", out_valid, 1'b0);

        // rst and flush together mid-stall
        drive(1'b0, 1'b1, 32'h77, 12'h0A5, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h78, 12'h0A5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h79, 12'h0A5, 1'b0, 1'b1);
        #1;
        check("rstflush_in_ready", in_ready, 1'b0);
        tick();
        check("rstflush_out_valid", out_valid, 1'b0);
        check("rstflush_out_data", out_data, 32'h0);
        check("rstflush_out_ctrl", out_ctrl, BUB);
        drive(1'b0, 1'b0, 32'h0, 12'h0, 1'b1, 1'b0);
        #1;
        check("rstflush_release_ready", in_ready, 1'b1);
        tick();
        check("rstflush_idle_valid", out_valid, 1'b0);
        check("rstflush_idle_data", out_data, 32'h0);
        check("rstflush_idle_ctrl", out_ctrl, BUB);

        // random traffic against a reference queue holding {ctrl,data}
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            drive(1'b0, $urandom_range(0, 9) < 7, $urandom, CW'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            #1;
            expRdy = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
            check("rnd_in_ready", in_ready, expRdy);
            check("rnd_out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                head = q[0];
                check("rnd_out_ctrl", out_ctrl, head[DW +: CW]);
                check("rnd_out_data", out_data, head[DW-1:0]);
            end else begin
                check("rnd_bubble_ctrl", out_ctrl, BUB);
            end
            acc = in_valid && expRdy;
            pop = (q.size() != 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back({in_ctrl, in_data});
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
